// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and universal
// shift register control codes.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHL  = 2'b01;
  localparam logic [1:0] CTRL_SHR  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left, shift right or parallel load,
// selected by a 2-bit control code. Serial-in bits come from the d word.
import shift_seq_pkg::*;

module univ_shift_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   ctrl,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (ctrl)
        CTRL_SHL:  q <= {q[N-2:0], d[0]};
        CTRL_SHR:  q <= {d[N-1], q[N-1:1]};
        CTRL_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial sequencer driving one univ_shift_reg; define
// SHIFT_SEQ_PARITY_EN to append an even-parity bit after the data bits.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | ready for a word; load the shift register on accept
// ST_SHIFT | emit one data bit per cycle, N cycles
// ST_PAR   | emit the registered parity bit (parity build only)
// ST_DONE  | one-cycle completion pulse
import shift_seq_pkg::*;

module shift_seq_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         msb_first,
  input  logic         abort,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            dir_q;
  logic [1:0]      ctrl;
  logic [N-1:0]    d;
  logic [N-1:0]    q;
  logic            accept;
`ifdef SHIFT_SEQ_PARITY_EN
  logic            par_q;
`endif

  // Only the end bits of q are observed; the rest just ride through the shifter.
  logic unused_q;
  assign unused_q = ^q;

  univ_shift_reg #(.N(N)) u_usr (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl),
    .d     (d),
    .q     (q)
  );

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    ctrl      = CTRL_HOLD;
    d         = '0;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !abort;
        if (in_valid && !abort) begin
          accept  = 1'b1;
          ctrl    = CTRL_LOAD;
          d       = in_data;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          ser_valid = 1'b1;
          ser_out   = dir_q ? q[N-1] : q[0];
          ctrl      = dir_q ? CTRL_SHL : CTRL_SHR;
          if (cnt_q == CNT_LAST) begin
`ifdef SHIFT_SEQ_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef SHIFT_SEQ_PARITY_EN
      ST_PAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          ser_valid = 1'b1;
          ser_out   = par_q;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        dir_q <= msb_first;
`ifdef SHIFT_SEQ_PARITY_EN
        par_q <= ^in_data;
`endif
      end else if (state_q == ST_SHIFT && !abort) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl at N=4; honours SHIFT_SEQ_PARITY_EN.
module tb_shift_seq_ctrl;

  localparam int N = 4;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int PAR_LEN = 1;
`else
  localparam int PAR_LEN = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         msb_first;
  logic         abort;
  logic         ser_out;
  logic         ser_valid;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  shift_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msb_first (msb_first),
    .abort     (abort),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit k (1-based) of a transfer, from the word and direction alone.
  function automatic logic exp_bit(input logic [N-1:0] w, input bit dir, input int k);
    if (k > N) return ^w;
    return dir ? w[N-k] : w[k-1];
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_sv"}, ser_valid, 0);
    chk({tag, "_so"}, ser_out, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b0; in_data = N'($urandom);
      #1 check_idle("idle");
    end
  endtask

  // One transfer; abort_at/reset_at select a cycle (1-based) to interrupt, 0 = none.
  // With hold=1, in_valid stays high with word nxt for the whole transfer.
  task automatic xfer(input logic [N-1:0] w, input bit dir, input int abort_at,
                      input int reset_at, input bit hold, input logic [N-1:0] nxt);
    int len;
    len = N + PAR_LEN;
    @(negedge clk);
    in_valid = 1'b1; in_data = w; msb_first = dir; abort = 1'b0;
    #1;
    chk("acc_ready", in_ready, 1);
    chk("acc_busy", busy, 0);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      in_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      in_data   = hold ? nxt : N'($urandom);
      msb_first = 1'($urandom_range(0, 1));
      if (k == abort_at) begin
        abort = 1'b1;
        #1;
        chk("abort_sv", ser_valid, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        #1 check_idle("post_abort");
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          #1 chk("abort_nodone", done, 0);
        end
        return;
      end
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1 check_idle("post_reset");
        return;
      end
      #1;
      chk("xf_busy", busy, 1);
      chk("xf_ready", in_ready, 0);
      if (k <= len) begin
        chk("xf_sv", ser_valid, 1);
        chk("xf_bit", ser_out, exp_bit(w, dir, k));
        chk("xf_done", done, 0);
      end else begin
        chk("xf_done", done, 1);
        chk("xf_done_sv", ser_valid, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; msb_first = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check_idle("reset");

    xfer(4'b1011, 1'b1, 0, 0, 1'b0, '0);
    xfer(4'b1011, 1'b0, 0, 0, 1'b0, '0);
    xfer(4'b1001, 1'b1, 0, 0, 1'b0, '0);
    idle(2);

    // Abort priority over in_valid while idle
    @(negedge clk);
    in_valid = 1'b1; abort = 1'b1; in_data = 4'hC;
    #1 chk("abort_idle_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    #1 check_idle("abort_idle");

    xfer(4'hE, 1'b1, 2, 0, 1'b0, '0);
    xfer(4'h6, 1'b0, 0, 0, 1'b0, '0);
    xfer(4'h9, 1'b0, N + PAR_LEN, 0, 1'b0, '0);

    // Back-to-back with in_valid held high
    xfer(4'hA, 1'b1, 0, 0, 1'b1, 4'h5);
    xfer(4'h5, 1'b1, 0, 0, 1'b0, '0);
    idle(1);

    xfer(4'h7, 1'b1, 0, 3, 1'b0, '0);
    xfer(4'h3, 1'b1, 0, 0, 1'b0, '0);

    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] w;
      w = N'($urandom);
      xfer(w, 1'($urandom_range(0, 1)), 0, 0, 1'b0, '0);
      idle(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
